// File: rtl/pixel_stream_pkg.sv
// Shared definitions for the pixel stream sequencer and the image read/write blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pixel_stream_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        VSYNC_DLY = 3'd1,
        LINE      = 3'd2,
        HBLANK    = 3'd3,
        DONE      = 3'd4
    } state_t;

    // Default image geometry shared with the image read/write blocks
    localparam int DEF_WIDTH  = 768;
    localparam int DEF_HEIGHT = 512;

endpackage

// File: rtl/pixel_stream_ctrl_cycle_timer.sv
// Loadable down-counter that stops at zero and flags it; reused for lead-in and blanking.
// Latency: a load of N raises zero after N further cycles (zero in the same cycle for N=0).
// Backpressure: none; counts every cycle until it reaches zero.
module cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Count down to zero; a load overrides the decrement
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pixel_stream_ctrl.sv
// Frame sequencer: VSYNC lead-in, per-line HSYNC windows with blanking, pixel-pair ADDR. BOTTOM_UP_EN selects bottom-up rows.
// Latency: VSYNC 1 cycle after start, first HSYNC START_DLY+1 cycles after start; all outputs registered.
// Backpressure: in LINE a pair advances only when ready=1; ADDR and HSYNC hold while ready=0.
module pixel_stream_ctrl
    import pixel_stream_pkg::state_t, pixel_stream_pkg::IDLE, pixel_stream_pkg::VSYNC_DLY,
           pixel_stream_pkg::LINE, pixel_stream_pkg::DONE,
           pixel_stream_pkg::DEF_WIDTH, pixel_stream_pkg::DEF_HEIGHT;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int HEIGHT    = DEF_HEIGHT,
    parameter int ADDR_W    = 20,
    parameter int START_DLY = 100,
    parameter int HBLANK    = 160
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              start,
    input  logic              ready,
    output logic              busy,
    output logic              VSYNC,
    output logic              HSYNC,
    output logic [ADDR_W-1:0] ADDR,
    output logic              frame_done,
    output logic              ctrl_done
);

    localparam int CW   = $clog2(WIDTH);
    localparam int RW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int TMAX = (START_DLY > HBLANK) ? START_DLY : HBLANK;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 2);
    localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);
    localparam logic [TW-1:0] VS_LOAD  = TW'(START_DLY - 1);
    localparam logic [TW-1:0] HB_LOAD  = TW'((HBLANK > 0) ? HBLANK - 1 : 0);

`ifdef BOTTOM_UP_EN
    // Bottom-up (BMP) order: start at the last row and walk the base downwards
    localparam logic [ADDR_W-1:0] FIRST_BASE = ADDR_W'((HEIGHT - 1) * WIDTH);
`else
    localparam logic [ADDR_W-1:0] FIRST_BASE = '0;
`endif

    state_t            state, state_nx;
    logic [CW-1:0]     col, col_nx;
    logic [RW-1:0]     row, row_nx;
    logic [ADDR_W-1:0] base, base_nx, addr_nx, base_step;
    logic              ctrl_done_nx;
    logic              tmr_load, tmr_zero;
    logic [TW-1:0]     tmr_val;

    cycle_timer #(.W(TW)) u_timer (
        .clk      (HCLK),
        .rst      (HRESET),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Next line base: one row away, wrapping modulo 2^ADDR_W
`ifdef BOTTOM_UP_EN
    assign base_step = base - ADDR_W'(WIDTH);
`else
    assign base_step = base + ADDR_W'(WIDTH);
`endif

    // State register
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state, address walk and timer control
    always_comb begin
        state_nx     = state;
        col_nx       = col;
        row_nx       = row;
        base_nx      = base;
        addr_nx      = ADDR;
        ctrl_done_nx = ctrl_done;
        tmr_load     = 1'b0;
        tmr_val      = VS_LOAD;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx     = VSYNC_DLY;
                    ctrl_done_nx = 1'b0;
                    tmr_load     = 1'b1;
                    tmr_val      = VS_LOAD;
                end
            end
            VSYNC_DLY: begin
                if (tmr_zero) begin
                    state_nx = LINE;
                    col_nx   = '0;
                    row_nx   = '0;
                    base_nx  = FIRST_BASE;
                    addr_nx  = FIRST_BASE;
                end
            end
            LINE: begin
                if (ready) begin
                    if (col == LAST_COL) begin
                        if (row == LAST_ROW) begin
                            state_nx     = DONE;
                            ctrl_done_nx = 1'b1;
                        end else begin
                            row_nx  = row + RW'(1);
                            col_nx  = '0;
                            base_nx = base_step;
                            addr_nx = base_step;
                            if (HBLANK == 0) begin
                                state_nx = LINE;
                            end else begin
                                state_nx = pixel_stream_pkg::HBLANK;
                                tmr_load = 1'b1;
                                tmr_val  = HB_LOAD;
                            end
                        end
                    end else begin
                        col_nx  = col + CW'(2);
                        addr_nx = ADDR + ADDR_W'(2);
                    end
                end
            end
            pixel_stream_pkg::HBLANK: begin
                if (tmr_zero) begin
                    state_nx = LINE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Datapath registers and outputs decoded from the next state so they align with it
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            col        <= '0;
            row        <= '0;
            base       <= '0;
            ADDR       <= '0;
            busy       <= 1'b0;
            VSYNC      <= 1'b0;
            HSYNC      <= 1'b0;
            frame_done <= 1'b0;
            ctrl_done  <= 1'b0;
        end else begin
            col        <= col_nx;
            row        <= row_nx;
            base       <= base_nx;
            ADDR       <= addr_nx;
            busy       <= (state_nx != IDLE);
            VSYNC      <= (state_nx == VSYNC_DLY);
            HSYNC      <= (state_nx == LINE);
            frame_done <= (state_nx == DONE);
            ctrl_done  <= ctrl_done_nx;
        end
    end

endmodule

// File: tb/tb_pixel_stream_ctrl.sv
// Scoreboard bench for pixel_stream_ctrl (WIDTH=4, HEIGHT=2, START_DLY=3, HBLANK=2).
// Stimulus pushes expected busy-cycle events; a negedge monitor pops and compares them.
// Expected address order follows BOTTOM_UP_EN when it is defined.
module tb_pixel_stream_ctrl;

    localparam int WIDTH  = 4;
    localparam int HEIGHT = 2;
    localparam int ADDR_W = 20;
    localparam int SD     = 3;
    localparam int HB     = 2;

    // Event kinds seen in a busy cycle
    localparam int K_VS   = 1;
    localparam int K_LINE = 2;
    localparam int K_HB   = 3;
    localparam int K_DONE = 4;

    logic              HCLK;
    logic              HRESET;
    logic              start;
    logic              ready;
    logic              busy;
    logic              VSYNC;
    logic              HSYNC;
    logic [ADDR_W-1:0] ADDR;
    logic              frame_done;
    logic              ctrl_done;

    typedef struct {
        int cyc;
        int kind;
        int addr;
    } ev_t;

    ev_t exp_q[$];
    int  cyc      = 0;
    int  n_checks = 0;
    int  n_fail   = 0;
    bit  mon_en   = 1'b0;
    int  seq[4];
    int  hb_addr;
    int  mon_kind;
    ev_t mon_ev;

    pixel_stream_ctrl #(
        .WIDTH     (WIDTH),
        .HEIGHT    (HEIGHT),
        .ADDR_W    (ADDR_W),
        .START_DLY (SD),
        .HBLANK    (HB)
    ) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .start      (start),
        .ready      (ready),
        .busy       (busy),
        .VSYNC      (VSYNC),
        .HSYNC      (HSYNC),
        .ADDR       (ADDR),
        .frame_done (frame_done),
        .ctrl_done  (ctrl_done)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic add_ev(input int e, input int k, input int max_k, input int kind, input int addr);
        ev_t ev;
        if (k <= max_k) begin
            ev.cyc  = e + k - 1;
            ev.kind = kind;
            ev.addr = addr;
            exp_q.push_back(ev);
        end
    endtask

    // Expected busy cycles of one frame whose start is sampled at edge e.
    // Stalls sit on the second pair of the first line; events beyond max_k are dropped.
    task automatic push_frame(input int e, input int stall, input int max_k);
        int k;
        k = 1;
        for (int i = 0; i < SD; i++) begin
            add_ev(e, k, max_k, K_VS, 0);
            k++;
        end
        for (int idx = 0; idx < 4; idx++) begin
            if (idx == 1) begin
                for (int s = 0; s < stall; s++) begin
                    add_ev(e, k, max_k, K_LINE, seq[idx]);
                    k++;
                end
            end
            add_ev(e, k, max_k, K_LINE, seq[idx]);
            k++;
            if (idx == 1) begin
                for (int h = 0; h < HB; h++) begin
                    add_ev(e, k, max_k, K_HB, hb_addr);
                    k++;
                end
            end
        end
        add_ev(e, k, max_k, K_DONE, 0);
    endtask

    // One full frame with an optional ready=0 stall on the second pair
    task automatic run_frame(input int stall);
        int e;
        start = 1'b1;
        e = cyc + 1;
        push_frame(e, stall, 1000);
        tick();
        start = 1'b0;
        for (int k = 1; k <= 11 + stall; k++) begin
            ready = !(k >= SD + 2 && k < SD + 2 + stall);
            tick();
        end
        ready = 1'b1;
        check_eq("frame_ctrl_done", ctrl_done, 1);
        check_eq("frame_idle_busy", busy, 0);
    endtask

    // Monitor: every busy cycle must match the next expected event
    always @(negedge HCLK) begin
        if (mon_en) begin
            if (busy === 1'b1) begin
                mon_kind = VSYNC ? K_VS : HSYNC ? K_LINE : frame_done ? K_DONE : K_HB;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_busy: cyc %0d kind %0d addr %0d, expected idle",
                             cyc, mon_kind, ADDR);
                end else begin
                    mon_ev = exp_q.pop_front();
                    if (mon_ev.cyc != cyc || mon_ev.kind != mon_kind ||
                        ((mon_kind == K_LINE || mon_kind == K_HB) && mon_ev.addr != int'(ADDR))) begin
                        n_fail++;
                        $display("FAIL event: got cyc %0d kind %0d addr %0d, expected cyc %0d kind %0d addr %0d",
                                 cyc, mon_kind, ADDR, mon_ev.cyc, mon_ev.kind, mon_ev.addr);
                    end
                end
            end else begin
                n_checks++;
                if ({busy, VSYNC, HSYNC, frame_done} !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL idle_outputs: got busy/vs/hs/fd %b, expected 0000 (cyc %0d)",
                             {busy, VSYNC, HSYNC, frame_done}, cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int e;
`ifdef BOTTOM_UP_EN
        seq     = '{4, 6, 0, 2};
        hb_addr = 0;
`else
        seq     = '{0, 2, 4, 6};
        hb_addr = 4;
`endif
        HRESET = 1'b1;
        start  = 1'b1;
        ready  = 1'b1;

        // Reset held two cycles with start high: nothing may move
        tick();
        mon_en = 1'b1;
        tick();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_vsync", VSYNC, 0);
        check_eq("rst_hsync", HSYNC, 0);
        check_eq("rst_frame_done", frame_done, 0);
        check_eq("rst_ctrl_done", ctrl_done, 0);
        check_eq("rst_addr", ADDR, 0);
        HRESET = 1'b0;
        start  = 1'b0;
        tick();
        check_eq("post_rst_busy", busy, 0);

        // Plain frame, then a frame with a 3-cycle stall on the second pair
        run_frame(0);
        run_frame(3);

        // start held high: back-to-back frames with one idle cycle between them
        start = 1'b1;
        e = cyc + 1;
        push_frame(e, 0, 1000);
        push_frame(e + 11, 0, 1000);
        tick();
        repeat (10) tick();
        check_eq("b2b_gap_busy", busy, 0);
        check_eq("b2b_gap_ctrl_done", ctrl_done, 1);
        tick();
        check_eq("b2b_restart_busy", busy, 1);
        check_eq("b2b_ctrl_done_cleared", ctrl_done, 0);
        start = 1'b0;
        repeat (11) tick();
        check_eq("b2b_end_ctrl_done", ctrl_done, 1);

        // Reset while the third pair address is on the bus in LINE
        start = 1'b1;
        e = cyc + 1;
        push_frame(e, 0, 8);
        tick();
        start = 1'b0;
        repeat (7) tick();
        check_eq("pre_rst_addr", ADDR, seq[2]);
        HRESET = 1'b1;
        tick();
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_vsync", VSYNC, 0);
        check_eq("midrst_hsync", HSYNC, 0);
        check_eq("midrst_frame_done", frame_done, 0);
        check_eq("midrst_ctrl_done", ctrl_done, 0);
        check_eq("midrst_addr", ADDR, 0);
        HRESET = 1'b0;
        tick();

        // Replay after the abandoned frame
        run_frame(0);

        repeat (3) tick();
        check_eq("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_stream_ctrl.md
Name: pixel_stream_ctrl

Overview:
- Frame sequencer for the two-pixels-per-clock image streaming datapath.
- On a start request it generates the VSYNC lead-in delay, per-line HSYNC (pixel-pair valid) windows with horizontal blanking, and the pixel-pair memory address (ADDR = index of the even pixel).
- Raises a completion pulse and a sticky done flag at end of frame.
- Sits between the top-level test/control logic and the pixel memory plus RGB output registers of the image reader; honours downstream back-pressure (ready).

Parameters:
- WIDTH, 768: pixels per line; must be even, >= 2.
- HEIGHT, 512: lines per frame; >= 1.
- ADDR_W, 20: address width; must hold WIDTH*HEIGHT-1.
- START_DLY, 100: cycles VSYNC is held high before the first line; >= 1.
- HBLANK, 160: idle cycles between lines; 0 allowed.

Ports:
- HCLK  in  1  clock; all logic on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- start  in  1  frame request; sampled only in IDLE.
- ready  in  1  downstream accepts the current pixel pair.
- busy  out  1  high in every state except IDLE.
- VSYNC  out  1  high during the START_DLY lead-in.
- HSYNC  out  1  pixel pair at ADDR is valid.
- ADDR  out  ADDR_W  pixel index of the even pixel of the current pair (odd pixel = ADDR+1).
- frame_done  out  1  one-cycle pulse at end of frame.
- ctrl_done  out  1  sticky done level.

Behaviour:
- Reset: state IDLE; busy, VSYNC, HSYNC, frame_done, ctrl_done all 0; ADDR 0; all counters 0. Reset has priority over every other event, including mid-frame; the partial frame is abandoned with no frame_done.
- IDLE: if start=1, go to VSYNC_DLY, clear ctrl_done, load the delay timer with START_DLY-1. Otherwise hold.
- VSYNC_DLY: VSYNC=1 for exactly START_DLY cycles, then go to LINE with col=0, row=0, line base = first row base.
- LINE: HSYNC=1.
  - A transfer occurs on each cycle with HSYNC&ready. On transfer, col += 2 and ADDR += 2.
  - With ready=0, ADDR and col hold and HSYNC stays 1.
  - On transfer of the last pair (col==WIDTH-2):
    - if row==HEIGHT-1, go to DONE;
    - else row++, line base advances one row, ADDR = new base, col=0, and go to HBLANK (or directly to LINE if HBLANK==0).
- HBLANK: HSYNC=0 and ADDR already holds the next line base, for exactly HBLANK cycles, then go to LINE.
- DONE: single cycle. frame_done=1, ctrl_done set to 1, busy=1, HSYNC=0. Next state is IDLE.
- ADDR arithmetic: incremental only, no multiplier. Line base advances by ±WIDTH modulo 2^ADDR_W. col width is clog2(WIDTH); row width is clog2(HEIGHT).
- start while busy, including in the DONE cycle: ignored, with no queueing.
- ready is ignored outside LINE.
- Latency:
  - start sampled at edge 0 → VSYNC high in cycles 1..START_DLY.
  - First HSYNC in cycle START_DLY+1.
  - With ready held high, frame_done in cycle START_DLY + HEIGHT*(WIDTH/2) + (HEIGHT-1)*HBLANK + 1.
- All outputs are registered.

Optional Feature:
- Macro BOTTOM_UP_EN.
- Defined: BMP bottom-up row order. First line base = (HEIGHT-1)*WIDTH (compile-time constant), and each new row decrements the base by WIDTH.
- Undefined: first line base = 0, and each new row increments the base by WIDTH.
- Column order within a line is ascending in both cases.

Decomposition:
- Shared package pixel_stream_pkg:
  - state encoding constants IDLE, VSYNC_DLY, LINE, HBLANK, DONE;
  - default WIDTH and HEIGHT shared with the image read/write blocks.
- One sub-module, cycle_timer: loadable down-counter with a zero flag. Instantiated once and reused for both the START_DLY and HBLANK intervals.

Test Plan (WIDTH=4, HEIGHT=2, START_DLY=3, HBLANK=2 unless stated):
- Hold HRESET=1 for 2 cycles with start=1 → all outputs 0, ADDR=0, and no state change.
- start pulse with ready=1 →
  - VSYNC=1 in cycles 1-3;
  - HSYNC with ADDR 0,2 in cycles 4-5;
  - HSYNC=0 with ADDR=4 in cycles 6-7;
  - HSYNC with ADDR 4,6 in cycles 8-9;
  - frame_done=1 in cycle 10, then busy=0 and ctrl_done=1.
- ready=0 for 3 cycles while ADDR=2 → ADDR holds 2 and HSYNC stays 1; frame_done is delayed to cycle 13.
- start=1 held continuously → frames run back-to-back. start in the DONE cycle is ignored, and a new frame begins on the cycle after IDLE is entered; ctrl_done clears on acceptance.
- HRESET asserted while ADDR=4 in LINE → next cycle all outputs 0; a subsequent start replays ADDR 0,2,4,6 and frame_done is produced.
- With BOTTOM_UP_EN defined → ADDR sequence is 4,6, then HBLANK with ADDR=0, then 0,2; HBLANK=0 variant gives no HSYNC gap between lines.
